i2c_xfer_engine: RTL and testbench

- Transaction-level I2C master engine. Sits directly downstream of the APB register interface and consumes its command handshake (slave address, register address, read/write, data byte).
- Executes one complete register access per command:
  - Write: START, SLA+W, 8- or 16-bit register address, data, STOP.
  - Read: START, SLA+W, register address, repeated START, SLA+R, data, master NACK, STOP.
- Drives SCL push-pull and SDA open-drain. Reports read data, completion, slave NACK and busy status back upstream.

---
 rtl/i2c_xfer_engine.sv | 186 ++++++++++++++++++
 tb/tb_i2c_xfer_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_engine.sv
// Transaction-level I2C master: one START..STOP register access per accepted command.
// SCL is driven push-pull, SDA open-drain; every symbol is four quarters of QDIV clocks.
module i2c_xfer_engine #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned I2C_FREQ = 250_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_bit_ctrl,
  input  logic        i_cmd_rh_wl,
  input  logic [7:0]  i_cmd_sladdr,
  input  logic [15:0] i_cmd_regaddr,
  input  logic        i_cmd_wvalid,
  output logic        o_cmd_wready,
  input  logic [7:0]  i_i2c_wdata,
  output logic [7:0]  o_i2c_rdata,
  output logic        o_i2c_rvalid,
  output logic        i2c_scl,
  inout  wire         i2c_sda,
  output logic        o_i2c_done,
  output logic        o_i2c_ack,
  output logic        o_i2c_busy
);
  localparam int unsigned QDIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned QW   = $clog2(QDIV);

  typedef enum logic [3:0] {
    IDLE, START, SLA_W, REG_HI, REG_LO, WDATA, RSTART, SLA_R, RDATA, STOP, DONE
  } state_t;

  state_t        state, nxt_state, after_byte;
  logic [QW-1:0] qcnt, nxt_qcnt;
  logic [1:0]    quarter, nxt_quarter;
  logic [3:0]    bit_idx, nxt_bit;
  logic          bc, rw, ack_bit, sda_rel, sda_in;
  logic [6:0]    sla;
  logic [15:0]   ra;
  logic [7:0]    wd, rxd, tx_byte;
  logic          tx_bit, q_end, sym_end, byte_end, sample, in_byte, accept, rx_done, nack_hit;
  logic          unused_sla_msb;

  assign unused_sla_msb = i_cmd_sladdr[7];
  assign i2c_sda  = sda_rel ? 1'bz : 1'b0;
  assign sda_in   = i2c_sda;

  assign q_end    = (qcnt == QW'(QDIV - 1));
  assign sym_end  = q_end && (quarter == 2'd3);
  assign byte_end = sym_end && (bit_idx == 4'd8);
  assign sample   = (quarter == 2'd3) && (qcnt == '0);
  assign in_byte  = state inside {SLA_W, REG_HI, REG_LO, WDATA, SLA_R, RDATA};
  assign accept   = (state == IDLE) && i_cmd_wvalid;
  assign rx_done  = (state == RDATA) && byte_end;
  assign nack_hit = in_byte && (state != RDATA) && byte_end && ack_bit;

  // {scl, sda_release} for a given symbol quarter
  function automatic logic [1:0] lines(input state_t st, input logic [1:0] q, input logic b);
    logic [1:0] l;
    case (st)
      START, RSTART: begin
        case (q)
          2'd0:    l = 2'b01;
          2'd1:    l = 2'b11;
          2'd2:    l = 2'b10;
          default: l = 2'b00;
        endcase
      end
      STOP: begin
        case (q)
          2'd0:    l = 2'b00;
          2'd1:    l = 2'b10;
          default: l = 2'b11;
        endcase
      end
      SLA_W, REG_HI, REG_LO, WDATA, SLA_R, RDATA: l = {q[1], b};
      default: l = 2'b11;
    endcase
    return l;
  endfunction

  // Symbol sequencing: quarter counter, bit counter and byte-to-byte routing
  always_comb begin
    nxt_state   = state;
    nxt_qcnt    = qcnt;
    nxt_quarter = quarter;
    nxt_bit     = bit_idx;
    if ((state != RDATA) && ack_bit) begin
      after_byte = STOP;
    end else begin
      case (state)
        SLA_W:   after_byte = bc ? REG_HI : REG_LO;
        REG_HI:  after_byte = REG_LO;
        REG_LO:  after_byte = rw ? RSTART : WDATA;
        SLA_R:   after_byte = RDATA;
        default: after_byte = STOP;
      endcase
    end
    case (state)
      IDLE: begin
        if (i_cmd_wvalid) begin
          nxt_state   = START;
          nxt_qcnt    = '0;
          nxt_quarter = 2'd0;
          nxt_bit     = 4'd0;
        end
      end
      DONE: nxt_state = IDLE;
      default: begin
        nxt_qcnt = q_end ? '0 : qcnt + QW'(1);
        if (q_end) nxt_quarter = quarter + 2'd1;
        if (sym_end) begin
          case (state)
            START:  nxt_state = SLA_W;
            RSTART: nxt_state = SLA_R;
            STOP:   nxt_state = DONE;
            default: begin
              nxt_bit = byte_end ? 4'd0 : bit_idx + 4'd1;
              if (byte_end) nxt_state = after_byte;
            end
          endcase
        end
      end
    endcase
  end

  // Bit presented on SDA in the upcoming symbol; ack bits and read bytes are released
  always_comb begin
    case (nxt_state)
      SLA_W:   tx_byte = {sla, 1'b0};
      REG_HI:  tx_byte = ra[15:8];
      REG_LO:  tx_byte = ra[7:0];
      WDATA:   tx_byte = wd;
      SLA_R:   tx_byte = {sla, 1'b1};
      default: tx_byte = 8'hFF;
    endcase
    tx_bit = nxt_bit[3] | tx_byte[3'd7 - nxt_bit[2:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      qcnt         <= '0;
      quarter      <= 2'd0;
      bit_idx      <= 4'd0;
      bc           <= 1'b0;
      rw           <= 1'b0;
      sla          <= 7'd0;
      ra           <= 16'd0;
      wd           <= 8'd0;
      rxd          <= 8'd0;
      ack_bit      <= 1'b0;
      i2c_scl      <= 1'b1;
      sda_rel      <= 1'b1;
      o_cmd_wready <= 1'b1;
      o_i2c_busy   <= 1'b0;
      o_i2c_done   <= 1'b0;
      o_i2c_rvalid <= 1'b0;
      o_i2c_rdata  <= 8'd0;
      o_i2c_ack    <= 1'b0;
    end else begin
      state                <= nxt_state;
      qcnt                 <= nxt_qcnt;
      quarter              <= nxt_quarter;
      bit_idx              <= nxt_bit;
      {i2c_scl, sda_rel}   <= lines(nxt_state, nxt_quarter, tx_bit);
      o_cmd_wready         <= (nxt_state == IDLE);
      o_i2c_busy           <= (nxt_state != IDLE);
      o_i2c_done           <= (nxt_state == DONE);
      o_i2c_rvalid         <= rx_done;
      if (rx_done) o_i2c_rdata <= rxd;
      if (accept) begin
        bc        <= i_cmd_bit_ctrl;
        rw        <= i_cmd_rh_wl;
        sla       <= i_cmd_sladdr[6:0];
        ra        <= i_cmd_regaddr;
        wd        <= i_i2c_wdata;
        o_i2c_ack <= 1'b0;
      end
      if (in_byte && sample) begin
        ack_bit <= sda_in;
        if ((state == RDATA) && !bit_idx[3]) rxd <= {rxd[6:0], sda_in};
      end
      if (nack_hit) o_i2c_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_engine.sv
// Self-checking bench for i2c_xfer_engine: a quarter-by-quarter bus model built from the
// transaction description drives a slave on SDA and checks every observable output.
module tb_i2c_xfer_engine;
  localparam int unsigned CLK_FREQ = 4_000_000;
  localparam int unsigned I2C_FREQ = 250_000;
  localparam int QDIV = 4;

  typedef struct {
    bit        bc;
    bit        rw;
    bit [7:0]  sla;
    bit [15:0] ra;
    bit [7:0]  wd;
    bit [7:0]  rb;
    int        nack_pos;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        bc, rw, wvalid, wready, rvalid, scl, done, ack, busy;
  logic [7:0]  sla, wd, rdata;
  logic [15:0] ra;
  logic        sda_low = 1'b0;
  wire         sda;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_xfer_engine #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_bit_ctrl(bc), .i_cmd_rh_wl(rw), .i_cmd_sladdr(sla), .i_cmd_regaddr(ra),
    .i_cmd_wvalid(wvalid), .o_cmd_wready(wready), .i_i2c_wdata(wd),
    .o_i2c_rdata(rdata), .o_i2c_rvalid(rvalid), .i2c_scl(scl), .i2c_sda(sda),
    .o_i2c_done(done), .o_i2c_ack(ack), .o_i2c_busy(busy)
  );

  always #5 clk = ~clk;

  int         n_err = 0;
  int         n_checks = 0;
  bit         q_scl[$], q_sda[$], q_slv[$];
  int         exp_done, exp_rv_at;
  bit         exp_ack, exp_rv;
  logic [7:0] last_rdata = 8'h00;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bus model: each entry is one quarter {scl, sda line, slave release}
  task automatic push_q(input bit s, input bit d, input bit v);
    q_scl.push_back(s); q_sda.push_back(d); q_slv.push_back(v);
  endtask

  task automatic push_start();
    push_q(0, 1, 1); push_q(1, 1, 1); push_q(1, 0, 1); push_q(0, 0, 1);
  endtask

  task automatic push_stop();
    push_q(0, 0, 1); push_q(1, 0, 1); push_q(1, 1, 1); push_q(1, 1, 1);
  endtask

  task automatic push_bit(input bit m, input bit s);
    push_q(0, m & s, s); push_q(0, m & s, s); push_q(1, m & s, s); push_q(1, m & s, s);
  endtask

  task automatic push_wbyte(input bit [7:0] b, input bit slave_nack);
    for (int i = 7; i >= 0; i--) push_bit(b[i], 1'b1);
    push_bit(1'b1, slave_nack);
  endtask

  task automatic build_model(input cmd_t c);
    bit [7:0] wb[$];
    bit       nacked = 1'b0;
    int       nq;
    q_scl.delete(); q_sda.delete(); q_slv.delete();
    wb.push_back({c.sla[6:0], 1'b0});
    if (c.bc) wb.push_back(c.ra[15:8]);
    wb.push_back(c.ra[7:0]);
    if (!c.rw) wb.push_back(c.wd);
    push_start();
    for (int k = 0; k < wb.size(); k++) begin
      push_wbyte(wb[k], k == c.nack_pos);
      if (k == c.nack_pos) begin
        nacked = 1'b1;
        break;
      end
    end
    if (c.rw && !nacked) begin
      push_start();
      push_wbyte({c.sla[6:0], 1'b1}, c.nack_pos == wb.size());
      if (c.nack_pos == wb.size()) nacked = 1'b1;
      else begin
        for (int i = 7; i >= 0; i--) push_bit(1'b1, c.rb[i]);
        push_bit(1'b1, 1'b1);
      end
    end
    push_stop();
    nq        = q_scl.size();
    exp_done  = 1 + nq * QDIV;
    exp_rv_at = 1 + (nq - 4) * QDIV;
    exp_ack   = nacked;
    exp_rv    = c.rw && !nacked;
  endtask

  task automatic drive(input cmd_t c, input logic v);
    bc = c.bc; rw = c.rw; sla = c.sla; ra = c.ra; wd = c.wd; wvalid = v;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.bc = 1'($urandom); c.rw = 1'($urandom);
    c.sla = 8'($urandom); c.ra = 16'($urandom);
    c.wd = 8'($urandom); c.rb = 8'($urandom);
    c.nack_pos = int'($urandom_range(0, 14));
    return c;
  endfunction

  task automatic run(input cmd_t c, input bit chained, input bit b2b, input cmd_t nx,
                     input int abort_at, input string nm);
    int         n_done = 0, done_at = -1, n_rv = 0, rv_at = -1, qi, nq;
    logic [7:0] rv_data = 8'h00;
    build_model(c);
    nq = q_scl.size();
    if (!chained) begin
      @(negedge clk);
      drive(c, 1'b1);
      chk1({nm, "_wready_idle"}, wready, 1'b1);
      @(posedge clk);
    end
    for (int cy = 1; cy <= exp_done + 1; cy++) begin
      #1;
      if (cy == 1) begin
        if (b2b) drive(nx, 1'b1);
        else drive(rand_cmd(), 1'b0);
      end
      qi = (cy - 1) / QDIV;
      sda_low = (qi < nq) ? !q_slv[qi] : 1'b0;
      @(negedge clk);
      if (cy == 1) begin
        chk1({nm, "_busy_c1"}, busy, 1'b1);
        chk1({nm, "_wready_c1"}, wready, 1'b0);
        chk1({nm, "_ack_clr"}, ack, 1'b0);
      end
      if (qi < nq && (cy - 1) % QDIV == 1) begin
        chk1($sformatf("%s_scl_q%0d", nm, qi), scl, q_scl[qi]);
        chk1($sformatf("%s_sda_q%0d", nm, qi), sda, q_sda[qi]);
        chk1($sformatf("%s_busy_q%0d", nm, qi), busy, 1'b1);
      end
      if (done === 1'b1) begin n_done++; done_at = cy; end
      if (rvalid === 1'b1) begin n_rv++; rv_at = cy; rv_data = rdata; end
      if (cy == exp_done) begin
        chk1({nm, "_ack"}, ack, exp_ack);
        chk1({nm, "_busy_done"}, busy, 1'b1);
        chk1({nm, "_wready_done"}, wready, 1'b0);
        chk8({nm, "_rdata_hold"}, rdata, exp_rv ? 8'(c.rb) : last_rdata);
      end
      if (cy == exp_done + 1) begin
        chk1({nm, "_busy_after"}, busy, 1'b0);
        chk1({nm, "_wready_after"}, wready, 1'b1);
      end
      if (cy == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sda_low = 1'b0;
        @(negedge clk);
        chk1({nm, "_rst_scl"}, scl, 1'b1);
        chk1({nm, "_rst_sda"}, sda, 1'b1);
        chk1({nm, "_rst_busy"}, busy, 1'b0);
        chk1({nm, "_rst_wready"}, wready, 1'b1);
        chk1({nm, "_rst_done"}, done, 1'b0);
        chk1({nm, "_rst_ack"}, ack, 1'b0);
        chk8({nm, "_rst_rdata"}, rdata, 8'h00);
        last_rdata = 8'h00;
        n_done = 0;
        repeat (8) begin
          @(negedge clk);
          if (done === 1'b1) n_done++;
        end
        chki({nm, "_no_done_after_rst"}, n_done, 0);
        return;
      end
      @(posedge clk);
    end
    chki({nm, "_done_pulses"}, n_done, 1);
    chki({nm, "_done_cycle"}, done_at, exp_done);
    chki({nm, "_rvalid_pulses"}, n_rv, exp_rv ? 1 : 0);
    if (exp_rv) begin
      chki({nm, "_rvalid_cycle"}, rv_at, exp_rv_at);
      chk8({nm, "_rdata"}, rv_data, c.rb);
      last_rdata = c.rb;
    end
  endtask

  initial begin
    cmd_t w8, r16, nk, a, b, none;
    rst = 1'b1;
    none = rand_cmd();
    drive(none, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_scl", scl, 1'b1);
    chk1("reset_sda", sda, 1'b1);
    chk1("reset_wready", wready, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_rvalid", rvalid, 1'b0);
    chk1("reset_ack", ack, 1'b0);
    chk8("reset_rdata", rdata, 8'h00);
    rst = 1'b0;

    w8  = '{bc: 1'b0, rw: 1'b0, sla: 8'h50, ra: 16'h00A5, wd: 8'h3C, rb: 8'h00, nack_pos: 99};
    run(w8, 1'b0, 1'b0, none, 0, "wr8");
    chki("wr8_done_at_465", exp_done, 465);

    r16 = '{bc: 1'b1, rw: 1'b1, sla: 8'h50, ra: 16'h1234, wd: 8'h00, rb: 8'h5A, nack_pos: 99};
    run(r16, 1'b0, 1'b0, none, 0, "rd16");
    chki("rd16_done_at_769", exp_done, 769);

    nk  = '{bc: 1'b0, rw: 1'b0, sla: 8'h50, ra: 16'h00A5, wd: 8'h3C, rb: 8'h00, nack_pos: 0};
    run(nk, 1'b0, 1'b0, none, 0, "nack_sla");
    chki("nack_done_at_177", exp_done, 177);

    a = rand_cmd(); a.nack_pos = 99;
    b = rand_cmd(); b.rw = 1'b1; b.nack_pos = 99;
    run(a, 1'b0, 1'b1, b, 0, "b2b_first");
    run(b, 1'b1, 1'b0, none, 0, "b2b_second");

    a = w8;
    run(a, 1'b0, 1'b0, none, 170, "abort");
    run(r16, 1'b0, 1'b0, none, 0, "post_abort");

    for (int i = 0; i < 8; i++) begin
      run(rand_cmd(), 1'b0, 1'b0, none, 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
